// File: rtl/pulse_to_level_pkg.sv
// Shared types and constants for the strobe-to-level stretcher.
// Holds the FSM state encoding and the counter-width helpers.
package pulse_to_level_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int h, input int g);
    int m;
    m = (h > g) ? h : g;
    return clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pulse_to_level.sv
// Stretches one-cycle strobes into HOLD_CYCLES-long levels with a GAP_CYCLES low gap.
// Ports: i_clk, i_rst_n (sync, active-low), i_pulse in; o_level, o_busy, o_done, o_overrun out.
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter bit          RETRIGGER   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pulse,
  output logic o_level,
  output logic o_busy,
  output logic o_done,
  output logic o_overrun
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..65535");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("GAP_CYCLES out of range 1..65535");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          drop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_pulse) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - ONE;
        // A retrigger reload wins over the end-of-hold check.
        if (i_pulse && RETRIGGER) begin
          cnt_d = HOLD_LD;
        end else begin
          if (i_pulse) begin
            if (pend_q) drop = 1'b1;
            else        pend_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q - ONE;
        if (i_pulse) begin
          if (pend_q) drop = 1'b1;
          else        pend_d = 1'b1;
        end
        if (cnt_q == '0) begin
          // pend_d folds in a pulse arriving on this last gap cycle.
          if (pend_d) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    level_d = (state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_HOLD) && (state_d == ST_GAP);
    ovr_d   = drop;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_level   = level_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// Bench for pulse_to_level: both retrigger modes side by side.
// Per-scenario tables of input/expected masks feed a scoreboard queue.
module tb_pulse_to_level;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse = 1'b0;
  logic lvl0, busy0, done0, ovr0;
  logic lvl1, busy1, done1, ovr1;

  always #5 clk = ~clk;

  pulse_to_level #(
    .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b0)
  ) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse),
    .o_level(lvl0), .o_busy(busy0),
    .o_done(done0), .o_overrun(ovr0)
  );

  pulse_to_level #(
    .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b1)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse),
    .o_level(lvl1), .o_busy(busy1),
    .o_done(done1), .o_overrun(ovr1)
  );

  typedef struct packed {
    logic [31:0] lvl;
    logic [31:0] busy;
    logic [31:0] done;
    logic [31:0] ovr;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] rst_lo;
    logic [31:0] pls;
    exp_t        e0;
    exp_t        e1;
  } vec_t;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] x0;
    logic [3:0] x1;
  } sb_t;

  localparam int NSCN = 7;
  localparam int NCYC = 30;

  vec_t tbl [NSCN];
  sb_t  sbq [$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] bt(input int b);
    return rng(b, b);
  endfunction

  function automatic exp_t mk(input logic [31:0] l, input logic [31:0] b,
                              input logic [31:0] d, input logic [31:0] o);
    exp_t e;
    e.lvl = l; e.busy = b; e.done = d; e.ovr = o;
    return e;
  endfunction

  function automatic logic [3:0] at(input exp_t e, input int k);
    return {e.lvl[k], e.busy[k], e.done[k], e.ovr[k]};
  endfunction

  task automatic cmp(input string nm, input int r, input int cyc,
                     input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s r%0d cyc %0d got lvl/busy/done/ovr=%b exp %b",
                  nm, r, cyc, got, exp);
  endtask

  initial begin
    exp_t z;
    exp_t single;
    exp_t two0;
    sb_t  s;
    z      = mk('0, '0, '0, '0);
    single = mk(rng(11, 14), rng(11, 16), bt(15), '0);
    two0   = mk(rng(11, 14) | rng(17, 20), rng(11, 22), bt(15) | bt(21), '0);

    tbl[0] = '{"reset", rng(0, 2), bt(0) | bt(2), z, z};
    tbl[1] = '{"single", rng(0, 2), bt(10), single, single};
    tbl[2] = '{"two", rng(0, 2), bt(10) | bt(12), two0,
               mk(rng(11, 16), rng(11, 18), bt(17), '0)};
    tbl[3] = '{"three", rng(0, 2), bt(10) | bt(12) | bt(13),
               mk(two0.lvl, two0.busy, two0.done, bt(14)),
               mk(rng(11, 17), rng(11, 19), bt(18), '0)};
    tbl[4] = '{"rst_mid", rng(0, 2) | bt(12), bt(10) | bt(12),
               mk(rng(11, 12), rng(11, 12), '0, '0),
               mk(rng(11, 12), rng(11, 12), '0, '0)};
    tbl[5] = '{"gap_edge", rng(0, 2), bt(10) | bt(16), two0, two0};
    tbl[6] = '{"stream", rng(0, 2), rng(5, 12),
               mk(rng(6, 9) | rng(12, 15) | rng(18, 21), rng(6, 23),
                  bt(10) | bt(16) | bt(22), rng(8, 12)),
               mk(rng(6, 16), rng(6, 18), bt(17), '0)};

    @(negedge clk);
    for (int n = 0; n < NSCN; n++) begin
      for (int c = 0; c < NCYC; c++) begin
        rst_n = ~tbl[n].rst_lo[c];
        pulse = tbl[n].pls[c];
        s.name = tbl[n].name;
        s.cyc  = c + 1;
        s.x0   = at(tbl[n].e0, c + 1);
        s.x1   = at(tbl[n].e1, c + 1);
        sbq.push_back(s);
        @(posedge clk);
        @(negedge clk);
        s = sbq.pop_front();
        cmp(s.name, 0, s.cyc, {lvl0, busy0, done0, ovr0}, s.x0);
        cmp(s.name, 1, s.cyc, {lvl1, busy1, done1, ovr1}, s.x1);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pulse_to_level.md
Name: pulse_to_level

Overview:
- Converts single-cycle strobes into a level held high for exactly HOLD_CYCLES clocks, followed by a guaranteed low gap of GAP_CYCLES clocks.
- Sits between pulse-domain logic (timers, command decoders, button edge strobes) and level-consuming logic (LED/motor enables, slow-sampling peripherals).
- Supports retrigger (extend the active level) or queue-one (a second pulse becomes a second level) modes.
- Reports lost pulses.

Parameters:
- HOLD_CYCLES, 4, clocks o_level stays high per accepted pulse; legal range 1..65535.
- GAP_CYCLES, 2, minimum clocks o_level stays low after each high period; legal range 1..65535.
- RETRIGGER, 0, 1 = a pulse during HOLD reloads the hold count; 0 = a pulse during HOLD/GAP is queued (one deep).

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_pulse  input  1  input strobe; every clock it is high counts as one pulse
- o_level  output  1  stretched level, registered
- o_busy  output  1  high whenever not IDLE (HOLD or GAP), registered
- o_done  output  1  one-cycle strobe on the first low cycle after a HOLD period, registered
- o_overrun  output  1  one-cycle strobe, the cycle after a pulse was discarded, registered

Behaviour:
- Reset (i_rst_n=0 sampled on i_clk): state=IDLE, counter=0, pending=0. All outputs are 0 the following cycle. Reset overrides i_pulse and aborts any HOLD/GAP immediately.
- Counter width: ceil(log2(max(HOLD_CYCLES,GAP_CYCLES)))+1 bits, unsigned, down-counting.
- IDLE: o_level=0, o_busy=0.
  - i_pulse=1 → HOLD, counter=HOLD_CYCLES-1.
  - o_level rises the cycle after the pulse (latency 1).
- HOLD: o_level=1, o_busy=1.
  - Counter decrements each cycle.
  - i_pulse=1 with RETRIGGER=1 → counter reloads to HOLD_CYCLES-1. This has priority over counter==0, so the state stays HOLD.
  - i_pulse=1 with RETRIGGER=0 and pending=0 → pending=1.
  - i_pulse=1 with RETRIGGER=0 and pending=1 → pulse dropped; o_overrun=1 next cycle.
  - counter==0 and no reload → GAP, counter=GAP_CYCLES-1; o_done=1 in the first GAP cycle.
- GAP: o_level=0, o_busy=1.
  - Counter decrements each cycle.
  - i_pulse=1: sets pending if pending=0; otherwise dropped, with o_overrun=1 next cycle. This applies in both RETRIGGER modes.
  - counter==0 and (pending=1 or i_pulse=1) → HOLD, counter=HOLD_CYCLES-1, pending=0. A second pulse arriving on the same cycle as a set pending is dropped and flagged.
  - counter==0 and no pending/pulse → IDLE.
- Invariants: each HOLD period lasts exactly HOLD_CYCLES cycles (plus reloads); each GAP lasts exactly GAP_CYCLES; o_level never glitches.
- A continuously high i_pulse produces back-to-back HOLD/GAP cycles. In RETRIGGER=1 it produces a permanently high level.
- Out-of-range parameters are a compile-time error via generate-time check.

Decomposition:
- Shared header (included file) holds:
  - state encoding localparams ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2;
  - the clog2 constant function used for the counter width.
- No sub-module needed. Counter, pending flag and FSM live in one module, roughly 150 lines.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2 unless stated; cycle n = clock edge index):
- Reset: i_rst_n=0 cycles 0-2 with i_pulse toggling → o_level, o_busy, o_done, o_overrun all 0 through cycle 3.
- Single pulse at cycle 10 →
  - o_level=1 cycles 11-14;
  - o_done=1 at cycle 15 only;
  - o_busy=1 cycles 11-16, 0 at cycle 17.
- RETRIGGER=1, pulses at cycles 10 and 12 → o_level=1 cycles 11-16 (6 cycles), o_done at cycle 17, no o_overrun.
- RETRIGGER=0, pulses at cycles 10 and 12 →
  - o_level=1 cycles 11-14, 0 cycles 15-16, 1 cycles 17-20;
  - o_done at cycles 15 and 21.
- RETRIGGER=0, pulses at cycles 10, 12 and 13 → o_overrun=1 at cycle 14 only; exactly two high periods (11-14, 17-20).
- Reset mid-operation: pulses at cycles 10 and 12 (RETRIGGER=0), i_rst_n=0 at cycle 12 → o_level=0 from cycle 13, no second high period, o_busy=0 from cycle 13.
